// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding a UART transmitter over its enable/busy handshake.
// It buffers bus writes, drains them one byte per transmitter frame, and
// reports level, full/empty and a sticky overflow flag to the register logic.
module uart_tx_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [PAYLOAD_BITS-1:0]   wr_data,
  input  logic                      flush,
  input  logic                      ovf_clr,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      empty,
  output logic                      full,
  output logic                      overflow,
  output logic                      uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]   uart_tx_data,
  input  logic                      uart_tx_busy,
  output logic                      clk_req
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {DIdle, DIssue, DWait} state_e;

  logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic                    ovf_q, ovf_d;
  logic                    tx_en_q, tx_en_d;
  logic [PAYLOAD_BITS-1:0] tx_data_q, tx_data_d;
  state_e                  state_q, state_d;

  logic push, pop, ovf_set;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign wr_ready = ~full;
  assign push     = wr_valid & wr_ready & ~flush;
  // A full-write is rejected even if a pop frees a slot in the same cycle.
  assign ovf_set  = wr_valid & full;
  assign pop      = (state_q == DIdle) & ~empty & ~uart_tx_busy & ~flush;
  assign clk_req  = ~empty | (state_q != DIdle) | uart_tx_busy;

  assign level        = level_q;
  assign overflow     = ovf_q;
  assign uart_tx_en   = tx_en_q;
  assign uart_tx_data = tx_data_q;

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointer, level and overflow next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
    // Set wins over a simultaneous clear.
    ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  // Drain FSM: pop head in idle, strobe enable for one cycle, wait out busy.
  always_comb begin
    state_d   = state_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    unique case (state_q)
      DIdle: begin
        if (pop) begin
          tx_data_d = mem_q[rd_ptr_q];
          tx_en_d   = 1'b1;
          state_d   = DIssue;
        end
      end
      DIssue: state_d = DWait;
      DWait: begin
        if (!uart_tx_busy) state_d = DIdle;
      end
      default: state_d = DIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      state_q   <= DIdle;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      state_q   <= state_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed stimulus with a transmitter model; bytes
// expected on the transmitter side are queued at issue time and checked by a
// separate monitor on every enable strobe.
module tb_uart_tx_fifo;

  localparam int unsigned Depth = 16;
  localparam int unsigned Frame = 3;

  logic       clk;
  logic       resetn;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       flush;
  logic       ovf_clr;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy;
  logic       clk_req;

  logic       hold_busy;
  logic       busy_m;
  int         frame_cnt;

  int         pass_cnt = 0;
  int         chk_cnt  = 0;
  int         tx_seen  = 0;
  logic [7:0] exp_q[$];
  logic       prev_en  = 1'b0;

  uart_tx_fifo #(
    .DEPTH        (Depth),
    .PAYLOAD_BITS (8)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .flush        (flush),
    .ovf_clr      (ovf_clr),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_busy (uart_tx_busy),
    .clk_req      (clk_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: busy registered, rises the cycle after an accepted en.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_m    <= 1'b0;
      frame_cnt <= 0;
    end else if (uart_tx_en && !busy_m) begin
      busy_m    <= 1'b1;
      frame_cnt <= Frame;
    end else if (busy_m) begin
      if (frame_cnt == 0) busy_m <= 1'b0;
      else                frame_cnt <= frame_cnt - 1;
    end
  end
  assign uart_tx_busy = busy_m | hold_busy;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every enable strobe pops the scoreboard and must last one cycle.
  always @(negedge clk) begin
    if (resetn && uart_tx_en) begin
      tx_seen++;
      chk_cnt++;
      if (exp_q.size() > 0) begin
        pass_cnt++;
        check("tx_data", int'(uart_tx_data), int'(exp_q.pop_front()));
      end else begin
        $display("FAIL tx_en_unexpected: got strobe with data 0x%0h expected none", uart_tx_data);
      end
      check("tx_en_single_cycle", int'(prev_en), 0);
    end
    prev_en = resetn & uart_tx_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input bit exp_it);
    wr_valid = 1'b1;
    wr_data  = d;
    if (exp_it) exp_q.push_back(d);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (clk_req && n < 1000) begin
      tick();
      n++;
    end
    check(name, int'(clk_req), 0);
  endtask

  initial begin
    int base;
    int i;
    int n;
    resetn    = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    flush     = 1'b0;
    ovf_clr   = 1'b0;
    hold_busy = 1'b0;
    #3;
    check("rst_level", int'(level), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_tx_en", int'(uart_tx_en), 0);
    check("rst_tx_data", int'(uart_tx_data), 0);
    check("rst_wr_ready", int'(wr_ready), 1);
    #9 resetn = 1'b1;
    tick();

    // 1: single byte latency
    wr(8'hA5, 1'b1);
    check("t1_en_after_accept", int'(uart_tx_en), 0);
    check("t1_level_after_accept", int'(level), 1);
    tick();
    check("t1_en_second_edge", int'(uart_tx_en), 1);
    check("t1_data", int'(uart_tx_data), 'hA5);
    check("t1_level_after_pop", int'(level), 0);
    check("t1_empty", int'(empty), 1);
    tick();
    check("t1_en_dropped", int'(uart_tx_en), 0);
    wait_idle("t1_idle");

    // 2 + 5: fill while busy, overflow and its clear
    hold_busy = 1'b1;
    base = tx_seen;
    for (int k = 1; k <= 16; k++) wr(8'(k), 1'b1);
    check("t2_full", int'(full), 1);
    check("t2_wr_ready", int'(wr_ready), 0);
    check("t2_level", int'(level), 16);
    check("t2_no_ovf_yet", int'(overflow), 0);
    wr(8'h11, 1'b0);
    check("t2_ovf_set", int'(overflow), 1);
    check("t2_level_after_ovf", int'(level), 16);
    ovf_clr = 1'b1;
    wr(8'h12, 1'b0);
    check("t5_set_beats_clr", int'(overflow), 1);
    tick();
    ovf_clr = 1'b0;
    check("t5_clr_alone", int'(overflow), 0);
    hold_busy = 1'b0;
    wait_idle("t2_drain");
    check("t2_tx_count", tx_seen - base, 16);
    check("t2_level_end", int'(level), 0);

    // 3: simultaneous push/pop at level 5, then a wrapping stream
    hold_busy = 1'b1;
    for (int k = 0; k < 5; k++) wr(8'(8'h30 + k), 1'b1);
    check("t3_level5", int'(level), 5);
    hold_busy = 1'b0;
    wr_valid  = 1'b1;
    wr_data   = 8'h35;
    exp_q.push_back(8'h35);
    tick();
    wr_valid  = 1'b0;
    hold_busy = 1'b1;
    check("t3_level_same", int'(level), 5);
    check("t3_en_on_pushpop", int'(uart_tx_en), 1);
    hold_busy = 1'b0;
    i = 0;
    n = 0;
    while (i < 40 && n < 2000) begin
      if (!full) begin
        wr_valid = 1'b1;
        wr_data  = 8'(8'h40 + i);
        exp_q.push_back(wr_data);
        i++;
      end else begin
        wr_valid = 1'b0;
      end
      tick();
      n++;
    end
    wr_valid = 1'b0;
    check("t3_stream_issued", i, 40);
    wait_idle("t3_drain");
    check("t3_no_ovf", int'(overflow), 0);
    check("t3_level_end", int'(level), 0);

    // 4: flush with a byte in flight and a concurrent write
    wr(8'h70, 1'b1);
    tick();
    hold_busy = 1'b1;
    for (int k = 1; k <= 6; k++) wr(8'(8'h70 + k), 1'b0);
    check("t4_level6", int'(level), 6);
    base     = tx_seen;
    flush    = 1'b1;
    wr(8'h77, 1'b0);
    flush    = 1'b0;
    check("t4_level_flushed", int'(level), 0);
    check("t4_empty", int'(empty), 1);
    check("t4_no_ovf", int'(overflow), 0);
    hold_busy = 1'b0;
    wait_idle("t4_drain");
    check("t4_no_more_en", tx_seen - base, 0);
    check("t4_data_held", int'(uart_tx_data), 'h70);
    check("scoreboard_drained", exp_q.size(), 0);

    // 6: asynchronous reset during a strobe
    hold_busy = 1'b1;
    for (int k = 0; k < 4; k++) wr(8'(8'h80 + k), 1'b0);
    check("t6_level4", int'(level), 4);
    hold_busy = 1'b0;
    tick();
    check("t6_en_high", int'(uart_tx_en), 1);
    check("t6_level3", int'(level), 3);
    #2 resetn = 1'b0;
    #1;
    check("t6_en_async", int'(uart_tx_en), 0);
    check("t6_level_async", int'(level), 0);
    check("t6_empty_async", int'(empty), 1);
    check("t6_clk_req", int'(clk_req), 0);
    exp_q.delete();
    tick();
    resetn = 1'b1;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
